// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int PC_STEP = 2;

    localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;
    localparam logic [PC_W-1:0] DEF_LAST_PC  = 16'h001C;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FETCH  = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_HALTED = 2'd3;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } q_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - instruction memory, redirect and decode handshake bundle
interface instr_fetch_ctrl_if;
    import fetch_pkg::*;

    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instr;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_ready;

    modport master (
        output imem_pc, instr_valid, instr, instr_pc,
        input  imem_instr, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_pc, instr_valid, instr, instr_pc,
        output imem_instr, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry prefetch FIFO with flush; head register holds its value when emptied
module fetch_queue
    import fetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push_i,
    input  logic     pop_i,
    input  logic     flush_i,
    input  q_entry_t push_data_i,
    output logic [1:0] count_o,
    output logic     head_valid_o,
    output q_entry_t head_o
);

    q_entry_t   head_q, head_d;
    q_entry_t   tail_q, tail_d;
    logic [1:0] count_q, count_d;

    // Head is a dedicated register so the decode outputs stay stable once the queue drains.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_data_i;
                    else                 tail_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end else begin
                        head_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_o       = head_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - fetch PC sequencer with prefetch queue, redirect flush and end-of-program halt
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] LAST_PC  = DEF_LAST_PC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    instr_fetch_ctrl_if.master bus,
    output logic               halted
);

    logic [PC_W-1:0] pc_q, pc_d;
    state_t          state_q, state_d;
    logic            push;
    logic            pop;
    logic [1:0]      q_count;
    q_entry_t        head;
    q_entry_t        push_entry;

    assign pop  = bus.instr_valid && bus.instr_ready;
    assign push = (state_q == ST_FETCH) && run && !bus.redirect_valid &&
                  ((q_count != 2'd2) || pop);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = bus.imem_instr;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.redirect_valid) begin
            state_d = ST_FETCH;
            pc_d    = bus.redirect_pc & ~PC_W'(1);
        end else begin
            if (push) pc_d = pc_q + PC_W'(PC_STEP);
            case (state_q)
                ST_IDLE:  if (run) state_d = ST_FETCH;
                ST_FETCH: if (push && (pc_q == LAST_PC)) state_d = ST_DRAIN;
                ST_DRAIN: if (q_count == 2'd0) state_d = ST_HALTED;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A pop in the redirect cycle is already accepted by decode; flushing drops the rest.
    fetch_queue u_queue (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (bus.redirect_valid),
        .push_data_i  (push_entry),
        .count_o      (q_count),
        .head_valid_o (bus.instr_valid),
        .head_o       (head)
    );

    assign bus.imem_pc  = pc_q;
    assign bus.instr    = head.instr;
    assign bus.instr_pc = head.pc;
    assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed self-checking bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic run;
    logic halted;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_ctrl_if bus ();

    assign bus.imem_instr = 16'hA000 + {12'h000, bus.imem_pc[4:1]};

    instr_fetch_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .bus     (bus),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        run = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        run = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_queue: valid=%b instr=%h pc=%h required 0/0000/0000",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
        checks++;
        if (bus.imem_pc !== 16'h0000 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_halt: imem_pc=%h halted=%b required 0000/0", bus.imem_pc, halted);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        run = 1'b1;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_pc !== 16'h0000) begin
            errors++;
            $display("FAIL stream_first_push: valid=%b imem_pc=%h required 0/0000", bus.instr_valid, bus.imem_pc);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(2 * k) || bus.instr !== 16'hA000 + 16'(k)) begin
                errors++;
                $display("FAIL stream_word%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                         k, bus.instr_valid, bus.instr_pc, bus.instr, 16'(2 * k), 16'hA000 + 16'(k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        run = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.imem_pc !== 16'h0004) begin
            errors++;
            $display("FAIL stall_full: valid=%b pc=%h imem_pc=%h required 1/0000/0004",
                     bus.instr_valid, bus.instr_pc, bus.imem_pc);
        end
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(2 * k) || bus.instr !== 16'hA000 + 16'(k)) begin
                errors++;
                $display("FAIL stall_resume%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                         k, bus.instr_valid, bus.instr_pc, bus.instr, 16'(2 * k), 16'hA000 + 16'(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_to_end();
        logic [15:0] last_pc;
        int          n_acc;
        logic        seen;
        logic        done;
        last_pc = 16'hFFFF;
        n_acc = 0;
        seen = 1'b0;
        done = 1'b0;
        do_reset();
        run = 1'b1;
        bus.instr_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (bus.instr_valid && bus.instr_ready) begin
                last_pc = bus.instr_pc;
                n_acc++;
                seen = 1'b1;
            end else if (seen) begin
                checks++;
                if (halted !== 1'b0) begin
                    errors++;
                    $display("FAIL end_halt_early: halted=%b required 0 when queue just emptied", halted);
                end
                @(negedge clk);
                checks++;
                if (halted !== 1'b1) begin
                    errors++;
                    $display("FAIL end_halt: halted=%b required 1 one cycle after empty", halted);
                end
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL end_timeout: queue never drained, accepted=%0d required 15", n_acc);
        end
        checks++;
        if (last_pc !== 16'h001C || n_acc != 15) begin
            errors++;
            $display("FAIL end_last: last_pc=%h accepted=%0d required 001c/15", last_pc, n_acc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.imem_pc !== 16'h001E || halted !== 1'b1 || bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL end_hold: imem_pc=%h halted=%b valid=%b required 001e/1/0",
                     bus.imem_pc, halted, bus.instr_valid);
        end
    endtask

    task automatic test_halt_redirect();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0000;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || bus.imem_pc !== 16'h0000 || bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_redirect: halted=%b imem_pc=%h valid=%b required 0/0000/0",
                     halted, bus.imem_pc, bus.instr_valid);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(2 * k) || bus.instr !== 16'hA000 + 16'(k)) begin
                errors++;
                $display("FAIL halt_restart%0d: valid=%b pc=%h instr=%h required 1/%h/%h",
                         k, bus.instr_valid, bus.instr_pc, bus.instr, 16'(2 * k), 16'hA000 + 16'(k));
            end
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        run = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0009;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000) begin
            errors++;
            $display("FAIL redir_head: valid=%b pc=%h required 1/0000", bus.instr_valid, bus.instr_pc);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.imem_pc !== 16'h0008) begin
            errors++;
            $display("FAIL redir_flush: valid=%b imem_pc=%h required 0/0008", bus.instr_valid, bus.imem_pc);
        end
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0008 || bus.instr !== 16'hA004) begin
            errors++;
            $display("FAIL redir_target: valid=%b pc=%h instr=%h required 1/0008/a004",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h000A || bus.instr !== 16'hA005) begin
            errors++;
            $display("FAIL redir_next: valid=%b pc=%h instr=%h required 1/000a/a005",
                     bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0010;
        @(negedge clk);
        checks++;
        if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000 ||
            bus.imem_pc !== 16'h0000 || halted !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b instr=%h pc=%h imem_pc=%h halted=%b required 0/0000/0000/0000/0",
                     bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_pc, halted);
        end
        reset_n = 1'b1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_pc !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_idle: imem_pc=%h required 0000 (IDLE needs a cycle to start)", bus.imem_pc);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_pc !== 16'h0002) begin
            errors++;
            $display("FAIL midreset_fetch: imem_pc=%h required 0002", bus.imem_pc);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        run = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_run_to_end();
        test_halt_redirect();
        test_redirect_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
